// File: rtl/fifo_write_arbiter_if.sv
// rtl/fifo_write_arbiter_if.sv - producer and fifo write-port bundle for fifo_write_arbiter
interface fifo_write_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 32
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [NUM_REQ-1:0]            req;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            gnt;
   logic                          fifo_we;
   logic [DATA_WIDTH-1:0]         fifo_wdata;
   logic                          fifo_rd;
   logic [CW-1:0]                 credits;
   logic                          busy;

   modport master (
      output req, req_data, fifo_rd,
      input  gnt, fifo_we, fifo_wdata, credits, busy
   );

   modport slave (
      input  req, req_data, fifo_rd,
      output gnt, fifo_we, fifo_wdata, credits, busy
   );
endinterface

// File: rtl/fifo_write_arbiter.sv
// rtl/fifo_write_arbiter.sv - round-robin, burst-bounded, credit-gated arbiter for the fifo write port
module fifo_write_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 32,
   parameter int MAX_BURST  = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   fifo_write_arbiter_if.slave  bus
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int OW = $clog2(NUM_REQ);
   localparam int BW = $clog2(MAX_BURST + 1);
   localparam logic [CW-1:0] FULL_CREDITS = CW'(DEPTH);
   localparam logic [BW-1:0] BURST_LIMIT  = BW'(MAX_BURST);

   typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

   state_t                state;
   logic [OW-1:0]         owner;
   logic [BW-1:0]         beat_cnt;
   logic [CW-1:0]         credits;
   logic                  fifo_we_q;
   logic [DATA_WIDTH-1:0] fifo_wdata_q;

   logic                  keep;
   logic                  found;
   logic                  accept;
   logic [OW-1:0]         winner;
   logic [OW-1:0]         cand;
   logic [NUM_REQ-1:0]    gnt_c;
   logic [DATA_WIDTH-1:0] wdata_c;
   logic [CW:0]           cred_sum;
   logic [CW-1:0]         cred_next;

   // Scan starts at owner+1 so the previous owner is considered last.
   always_comb begin
      keep   = (state == BURST) && bus.req[owner] && (beat_cnt < BURST_LIMIT);
      found  = keep;
      winner = owner;
      cand   = owner;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand = OW'((int'(owner) + i) % NUM_REQ);
         if (!found && bus.req[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
      accept  = rst_n && (credits != '0) && found;
      wdata_c = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         gnt_c[j] = accept && (winner == OW'(j));
         if (winner == OW'(j)) wdata_c = bus.req_data[j*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   // A pop arriving while already full is illegal upstream; clamp rather than wrap.
   always_comb begin
      cred_sum  = {1'b0, credits} - {{CW{1'b0}}, accept} + {{CW{1'b0}}, bus.fifo_rd};
      cred_next = (cred_sum > {1'b0, FULL_CREDITS}) ? FULL_CREDITS : cred_sum[CW-1:0];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         owner        <= OW'(NUM_REQ - 1);
         beat_cnt     <= '0;
         credits      <= FULL_CREDITS;
         fifo_we_q    <= 1'b0;
         fifo_wdata_q <= '0;
      end else begin
         credits   <= cred_next;
         fifo_we_q <= accept;
         if (accept) begin
            fifo_wdata_q <= wdata_c;
            owner        <= winner;
            beat_cnt     <= keep ? beat_cnt + 1'b1 : BW'(1);
            state        <= BURST;
         end else if (bus.req == '0) begin
            state    <= IDLE;
            beat_cnt <= '0;
         end
      end
   end

   assign bus.gnt        = gnt_c;
   assign bus.fifo_we    = fifo_we_q;
   assign bus.fifo_wdata = fifo_wdata_q;
   assign bus.credits    = credits;
   assign bus.busy       = (state == BURST);
endmodule
